core_wb_arb: RTL and testbench

//  Parametrised write-back stage. Merges NUM_SRC result streams onto the single register-file write port.

---
 rtl/core_wb_arb_if.sv | 32 +++
 rtl/core_wb_arb.sv | 145 ++++++++++++++
 tb/tb_core_wb_arb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/core_wb_arb_if.sv
// Write-back bus between result sources and core_wb_arb.
// Handshake: source i transfers on src_valid[i] & src_ready[i]; src_ready never depends on src_valid.
interface core_wb_arb_if #(
  parameter int XLEN    = 64,
  parameter int RFIDX_W = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 64
);
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC-1:0]         src_ready;
  logic [NUM_SRC*RFIDX_W-1:0] src_rd_idx;
  logic [NUM_SRC*2-1:0]       src_mem2reg;
  logic [NUM_SRC*XLEN-1:0]    src_alu;
  logic [NUM_SRC*XLEN-1:0]    src_mem;
  logic [NUM_SRC*XLEN-1:0]    src_imm;
  logic [NUM_SRC*XLEN-1:0]    src_snpc;
  logic                       rf_we;
  logic [RFIDX_W-1:0]         rf_idx;
  logic [XLEN-1:0]            rf_data;
  logic [NUM_SRC-1:0]         pend_mask;
  logic [CNT_W-1:0]           retire_cnt;

  modport master (
    output src_valid, src_rd_idx, src_mem2reg, src_alu, src_mem, src_imm, src_snpc,
    input  src_ready, rf_we, rf_idx, rf_data, pend_mask, retire_cnt
  );

  modport slave (
    input  src_valid, src_rd_idx, src_mem2reg, src_alu, src_mem, src_imm, src_snpc,
    output src_ready, rf_we, rf_idx, rf_data, pend_mask, retire_cnt
  );
endinterface

// File: rtl/core_wb_arb.sv
// Write-back arbiter: per-source 1-entry slots, round-robin onto one register-file write port.
// Optional same-cycle write-through when all slots are empty: define CORE_WB_BYPASS_EN.
module core_wb_arb #(
  parameter int XLEN    = 64,
  parameter int RFIDX_W = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 64
) (
  input logic         clk,
  input logic         rst_n,
  core_wb_arb_if.slave bus
);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] slot_full_q, slot_full_d;
  logic [RFIDX_W-1:0] slot_idx_q  [NUM_SRC];
  logic [RFIDX_W-1:0] slot_idx_d  [NUM_SRC];
  logic [XLEN-1:0]    slot_data_q [NUM_SRC];
  logic [XLEN-1:0]    slot_data_d [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

  logic [XLEN-1:0]    sel_data [NUM_SRC];
  logic [RFIDX_W-1:0] sel_idx  [NUM_SRC];
  logic [NUM_SRC-1:0] grant, accept, byp_mask;
  logic               gnt_hit, byp_hit;
  logic [PTR_W-1:0]   gnt_src, byp_src, gnt_cand;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    return PTR_W'((int'(base) + off) % NUM_SRC);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_idx[i] = bus.src_rd_idx[i*RFIDX_W +: RFIDX_W];
      case (bus.src_mem2reg[i*2 +: 2])
        2'b00:   sel_data[i] = bus.src_alu[i*XLEN +: XLEN];
        2'b01:   sel_data[i] = bus.src_mem[i*XLEN +: XLEN];
        2'b10:   sel_data[i] = bus.src_imm[i*XLEN +: XLEN];
        default: sel_data[i] = bus.src_snpc[i*XLEN +: XLEN];
      endcase
    end
  end

  // First full slot scanning from rr_ptr wins.
  always_comb begin
    grant    = '0;
    gnt_hit  = 1'b0;
    gnt_src  = '0;
    gnt_cand = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      gnt_cand = wrap_add(rr_ptr_q, k);
      if (!gnt_hit && slot_full_q[gnt_cand]) begin
        gnt_hit = 1'b1;
        gnt_src = gnt_cand;
      end
    end
    if (gnt_hit) grant[gnt_src] = 1'b1;
  end

`ifdef CORE_WB_BYPASS_EN
  logic [PTR_W-1:0] byp_cand;
  always_comb begin
    byp_mask = '0;
    byp_hit  = 1'b0;
    byp_src  = '0;
    byp_cand = '0;
    if (slot_full_q == '0) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        byp_cand = wrap_add(rr_ptr_q, k);
        if (!byp_hit && bus.src_valid[byp_cand] && (sel_idx[byp_cand] != '0)) begin
          byp_hit = 1'b1;
          byp_src = byp_cand;
        end
      end
    end
    if (byp_hit) byp_mask[byp_src] = 1'b1;
  end
`else
  assign byp_mask = '0;
  assign byp_hit  = 1'b0;
  assign byp_src  = '0;
`endif

  assign bus.src_ready  = ~slot_full_q | grant;
  assign accept         = bus.src_valid & bus.src_ready;
  assign bus.pend_mask  = slot_full_q;
  assign bus.retire_cnt = retire_cnt_q;

  // Writes are suppressed while reset is asserted so a reset cycle never commits stale slot data.
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_idx  = '0;
    bus.rf_data = '0;
    if (rst_n) begin
      if (gnt_hit) begin
        bus.rf_we   = 1'b1;
        bus.rf_idx  = slot_idx_q[gnt_src];
        bus.rf_data = slot_data_q[gnt_src];
      end else if (byp_hit) begin
        bus.rf_we   = 1'b1;
        bus.rf_idx  = sel_idx[byp_src];
        bus.rf_data = sel_data[byp_src];
      end
    end
  end

  always_comb begin
    slot_full_d  = slot_full_q;
    slot_idx_d   = slot_idx_q;
    slot_data_d  = slot_data_q;
    retire_cnt_d = retire_cnt_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      retire_cnt_d = retire_cnt_d + CNT_W'(accept[i]);
      if (accept[i] && (sel_idx[i] != '0) && !byp_mask[i]) begin
        slot_full_d[i] = 1'b1;
        slot_idx_d[i]  = sel_idx[i];
        slot_data_d[i] = sel_data[i];
      end else if (grant[i]) begin
        slot_full_d[i] = 1'b0;
      end
    end
    if (gnt_hit)      rr_ptr_d = wrap_add(gnt_src, 1);
    else if (byp_hit) rr_ptr_d = wrap_add(byp_src, 1);
    else              rr_ptr_d = rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_full_q  <= '0;
      rr_ptr_q     <= '0;
      retire_cnt_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_idx_q[i]  <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      slot_full_q  <= slot_full_d;
      rr_ptr_q     <= rr_ptr_d;
      retire_cnt_q <= retire_cnt_d;
      slot_idx_q   <= slot_idx_d;
      slot_data_q  <= slot_data_d;
    end
  end
endmodule

// File: tb/tb_core_wb_arb.sv
// Randomised and directed bench for core_wb_arb against a slot-level behavioural model.
module tb_core_wb_arb;
  localparam int XLEN = 64, RFIDX_W = 5, N = 2, CNT_W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_wb_arb_if #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .NUM_SRC(N), .CNT_W(CNT_W)) bus ();
  core_wb_arb #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .NUM_SRC(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // driven stimulus
  bit          d_valid [N];
  logic [4:0]  d_idx   [N];
  logic [1:0]  d_mode  [N];
  logic [63:0] d_alu [N], d_mem [N], d_imm [N], d_snpc [N];

  // behavioural model: slot contents, round-robin pointer, retire count
  bit          m_known = 0;
  bit          m_full [N];
  logic [4:0]  m_idx  [N];
  logic [63:0] m_data [N];
  int          m_rr;
  logic [63:0] m_cnt;

  bit          contention = 0;
  logic [4:0]  wr_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pick(input int s);
    case (d_mode[s])
      2'b00:   return d_alu[s];
      2'b01:   return d_mem[s];
      2'b10:   return d_imm[s];
      default: return d_snpc[s];
    endcase
  endfunction

  task automatic set_src(input int s, input bit v, input int rd, input logic [1:0] mode,
                         input logic [63:0] alu, input logic [63:0] mem,
                         input logic [63:0] imm, input logic [63:0] snpc);
    d_valid[s] = v; d_idx[s] = 5'(rd); d_mode[s] = mode;
    d_alu[s] = alu; d_mem[s] = mem; d_imm[s] = imm; d_snpc[s] = snpc;
  endtask

  task automatic idle_all();
    for (int s = 0; s < N; s++) set_src(s, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      bus.src_valid[s]              = d_valid[s];
      bus.src_rd_idx[s*5 +: 5]      = d_idx[s];
      bus.src_mem2reg[s*2 +: 2]     = d_mode[s];
      bus.src_alu[s*64 +: 64]       = d_alu[s];
      bus.src_mem[s*64 +: 64]       = d_mem[s];
      bus.src_imm[s*64 +: 64]       = d_imm[s];
      bus.src_snpc[s*64 +: 64]      = d_snpc[s];
    end
  endtask

  // One clock: drive, check outputs mid-cycle against the model, advance the model at the edge.
  task automatic cycle();
    int g, b, j;
    bit e_we;
    logic [4:0] e_idx;
    logic [63:0] e_data;
    logic [N-1:0] e_ready, e_pend, acc;
    drive();
    @(negedge clk);
    g = -1; b = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (g < 0 && m_full[j]) g = j;
    end
`ifdef CORE_WB_BYPASS_EN
    if (g < 0)
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (b < 0 && d_valid[j] && d_idx[j] != 0) b = j;
      end
`endif
    e_we = 0; e_idx = 0; e_data = 0;
    if (rst_n && g >= 0) begin e_we = 1; e_idx = m_idx[g]; e_data = m_data[g]; end
    else if (rst_n && b >= 0) begin e_we = 1; e_idx = d_idx[b]; e_data = pick(b); end
    for (int s = 0; s < N; s++) begin
      e_ready[s] = !m_full[s] || (s == g);
      e_pend[s]  = m_full[s];
      acc[s]     = d_valid[s] && e_ready[s];
    end
    if (m_known) begin
      chk("rf_we", 64'(bus.rf_we), 64'(e_we));
      chk("rf_idx", 64'(bus.rf_idx), 64'(e_idx));
      chk("rf_data", bus.rf_data, e_data);
      chk("src_ready", 64'(bus.src_ready), 64'(e_ready));
      chk("pend_mask", 64'(bus.pend_mask), 64'(e_pend));
      chk("retire_cnt", bus.retire_cnt, m_cnt);
      if (contention) begin
        chk("ready_not_both0", 64'(bus.src_ready == '0), 64'd0);
        if (bus.rf_we) wr_q.push_back(bus.rf_idx);
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_known = 1; m_rr = 0; m_cnt = 0;
      for (int s = 0; s < N; s++) m_full[s] = 0;
    end else if (m_known) begin
      for (int s = 0; s < N; s++) begin
        if (acc[s]) m_cnt = m_cnt + 1;
        if (acc[s] && d_idx[s] != 0 && s != b) begin
          m_full[s] = 1; m_idx[s] = d_idx[s]; m_data[s] = pick(s);
        end else if (s == g) begin
          m_full[s] = 0;
        end
      end
      if (g >= 0)      m_rr = (g + 1) % N;
      else if (b >= 0) m_rr = (b + 1) % N;
    end
  endtask

  initial begin
    logic [63:0] cnt0;
    // reset held with both sources valid
    rst_n = 0;
    for (int s = 0; s < N; s++) set_src(s, 1, s + 1, 2'b00, 64'h11 + s, 0, 0, 0);
    repeat (3) cycle();
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_cnt", bus.retire_cnt, 64'd0);
    chk("rst_pend", 64'(bus.pend_mask), 64'd0);
    chk("rst_ready", 64'(bus.src_ready), 64'h3);

    // single mem result
    rst_n = 1;
    idle_all();
    set_src(0, 1, 5, 2'b01, 0, 64'hDEAD_BEEF, 0, 0);
    cycle();
    chk("single_cnt", bus.retire_cnt, 64'd1);
    idle_all();
    repeat (2) cycle();

    // select modes alu / imm / snpc
    set_src(0, 1, 3, 2'b00, 64'd1, 64'd9, 64'd2, 64'h8000_0004); cycle();
    set_src(0, 1, 3, 2'b10, 64'd1, 64'd9, 64'd2, 64'h8000_0004); cycle();
    set_src(0, 1, 3, 2'b11, 64'd1, 64'd9, 64'd2, 64'h8000_0004); cycle();
    idle_all();
    repeat (2) cycle();

    // x0 destination: counted, never stored
    cnt0 = m_cnt;
    set_src(1, 1, 0, 2'b00, 64'd7, 0, 0, 0);
    cycle();
    chk("x0_pend", 64'(bus.pend_mask), 64'd0);
    chk("x0_cnt", bus.retire_cnt, cnt0 + 1);
    idle_all();
    repeat (2) cycle();

    // contention: both valid every cycle
    contention = 1;
    set_src(0, 1, 1, 2'b00, 64'hA1, 0, 0, 0);
    set_src(1, 1, 2, 2'b00, 64'hB2, 0, 0, 0);
    repeat (10) cycle();
    contention = 0;
    chk("cont_writes", 64'(wr_q.size() >= 8), 64'd1);
    for (int i = 1; i < wr_q.size(); i++) chk("cont_alt", 64'(wr_q[i] != wr_q[i-1]), 64'd1);

    // reset mid-operation with slots full
    idle_all();
    rst_n = 0;
    cycle();
    rst_n = 1;
    cycle();
    chk("midrst_cnt", bus.retire_cnt, 64'd0);

    // randomised traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      for (int s = 0; s < N; s++)
        set_src(s, 1'($urandom_range(0, 1)), $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      cycle();
    end
    rst_n = 1;
    idle_all();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
